// File: rtl/prog_loader.sv
// Nibble-stream program loader with checksum and 16x8 instruction store.
// Define PROG_LOADER_BOOT_IMAGE_EN to preload the LED-counter image at reset.
module prog_loader #(
  parameter logic [7:0]  CKSUM_SEED = 8'h00,
  parameter int unsigned RUN_DELAY  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] adr,
  output logic [7:0] dout,
  output logic       cpu_reset,
  input  logic       ld_start,
  input  logic       ld_valid,
  input  logic [3:0] ld_data,
  output logic       ld_ready,
  output logic       busy,
  output logic       err
);

  typedef enum logic [2:0] {
    S_BOOT, S_RUN, S_LD_HI, S_LD_LO,
    S_CK_HI, S_CK_LO, S_HOLD, S_ERR
  } state_e;

  localparam logic [3:0] DLY_M1 = 4'(RUN_DELAY - 1);

  state_e     state_q, state_d;
  logic [3:0] ptr_q, ptr_d;
  logic [7:0] acc_q, acc_d;
  logic [3:0] hi_q, hi_d;
  logic [3:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic [7:0] mem_q [16];
  logic       we;
  logic [7:0] wdata;
  logic       xfer;
  logic       run;

  function automatic logic [7:0] boot_word(input int i);
`ifdef PROG_LOADER_BOOT_IMAGE_EN
    case (i)
      0:       boot_word = 8'hA0;
      1:       boot_word = 8'h30;
      2:       boot_word = 8'h60;
      3:       boot_word = 8'h91;
      default: boot_word = 8'h00;
    endcase
`else
    boot_word = (i < 0) ? 8'hFF : 8'h00;
`endif
  endfunction

  assign run       = (state_q == S_RUN);
  assign cpu_reset = run;
  assign dout      = run ? mem_q[adr] : 8'h00;
  assign ld_ready  = (state_q == S_LD_HI) || (state_q == S_LD_LO) ||
                     (state_q == S_CK_HI) || (state_q == S_CK_LO);
  assign busy      = ld_ready || (state_q == S_HOLD);
  assign err       = err_q;
  assign xfer      = ld_valid && ld_ready;
  assign wdata     = {hi_q, ld_data};

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    we      = 1'b0;
    unique case (state_q)
      S_BOOT: state_d = S_RUN;
      S_RUN, S_ERR: begin
        if (ld_start) begin
          state_d = S_LD_HI;
          ptr_d   = 4'd0;
          acc_d   = CKSUM_SEED;
          err_d   = 1'b0;
        end
      end
      S_LD_HI: begin
        if (xfer) begin
          hi_d    = ld_data;
          state_d = S_LD_LO;
        end
      end
      S_LD_LO: begin
        if (xfer) begin
          we    = 1'b1;
          acc_d = acc_q + wdata;
          if (ptr_q == 4'hF) begin
            state_d = S_CK_HI;
          end else begin
            ptr_d   = ptr_q + 4'd1;
            state_d = S_LD_HI;
          end
        end
      end
      S_CK_HI: begin
        if (xfer) begin
          hi_d    = ld_data;
          state_d = S_CK_LO;
        end
      end
      S_CK_LO: begin
        if (xfer) begin
          if (wdata == acc_q) begin
            state_d = S_HOLD;
            cnt_d   = DLY_M1;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (cnt_q == 4'd0) state_d = S_RUN;
        else cnt_d = cnt_q - 4'd1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_BOOT;
      ptr_q   <= 4'd0;
      acc_q   <= CKSUM_SEED;
      hi_q    <= 4'd0;
      cnt_q   <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Store is reset too so an abandoned load never leaves partial code behind.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) mem_q[i] <= boot_word(i);
    end else if (we) begin
      mem_q[ptr_q] <= wdata;
    end
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter CKSUM_SEED, default 8'h00: initial value of the load checksum accumulator.
REQ-002 SHALL have parameter RUN_DELAY, default 2: cycles (range 1-15) that cpu_reset stays low after a good load.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 reset  in  1  asynchronous, active-low; low forces reset state immediately, independent of clk.
REQ-005 adr  in  4  instruction address from the CPU program counter.
REQ-006 dout  out  8  instruction word to the CPU.
REQ-007 cpu_reset  out  1  active-low reset driven to the CPU.
REQ-008 ld_start  in  1  level-sampled request to begin a program load.
REQ-009 ld_valid  in  1  loader nibble valid.
REQ-010 ld_data  in  4  loader nibble.
REQ-011 ld_ready  out  1  loader nibble accept.
REQ-012 busy  out  1  high in any state other than RUN and ERR.
REQ-013 err  out  1  checksum mismatch on last load.

Function
REQ-014 Storage SHALL be 16 words x 8 bits, indexed 0-15.
REQ-015 FSM states SHALL be RUN, LD_HI, LD_LO, CK_HI, CK_LO, HOLD, ERR.
REQ-016 In RUN, dout SHALL equal mem[adr] combinationally (zero-cycle latency) and cpu_reset SHALL be 1. In all other states, dout SHALL be 8'h00 and cpu_reset SHALL be 0.
REQ-017 ld_ready SHALL be 1 only in LD_HI, LD_LO, CK_HI and CK_LO. A nibble transfers on a cycle with ld_valid=1 and ld_ready=1.
REQ-018 ld_start=1 in RUN or ERR SHALL cause a transition to LD_HI on the next edge, with the following effects: write pointer=0, accumulator=CKSUM_SEED, err cleared. ld_start SHALL be ignored in all other states.
REQ-019 LD_HI: a transfer SHALL latch ld_data as bits [7:4] and go to LD_LO.
REQ-020 LD_LO: a transfer SHALL write {hi,ld_data} to mem[pointer] and add the word to the accumulator mod 256.
REQ-021 On that LD_LO transfer, if pointer=15 the FSM SHALL go to CK_HI; otherwise pointer SHALL increment and the FSM SHALL return to LD_HI.
REQ-022 CK_HI SHALL latch the expected checksum bits [7:4]. CK_LO SHALL take bits [3:0] and compare the expected value to the accumulator.
REQ-023 On a checksum match, the FSM SHALL enter HOLD for exactly RUN_DELAY cycles, then RUN; cpu_reset rises on the first RUN cycle.
REQ-024 On a mismatch, the FSM SHALL set err=1 and enter ERR. ERR holds the CPU in reset until ld_start. Memory keeps the words already written.
REQ-025 Without ld_valid, every load state SHALL hold indefinitely; there is no timeout.
REQ-026 ld_valid while ld_ready=0 SHALL be ignored, and mem SHALL never be written outside LD_LO.
REQ-027 The pointer SHALL never wrap during a load; exactly 32 data nibbles plus 2 checksum nibbles constitute one load.

Reset
REQ-028 While reset=0, the block SHALL hold the following values: state=RUN-pending (cpu_reset=0), dout=8'h00, ld_ready=0, busy=0, err=0, pointer=0, accumulator=CKSUM_SEED.
REQ-029 On the first edge after reset deasserts, the FSM SHALL enter RUN with cpu_reset=1.
REQ-030 A reset mid-load SHALL abandon the load. Memory SHALL take its reset contents per REQ-031/032.

Configuration
REQ-031 With PROG_LOADER_BOOT_IMAGE_EN defined, reset SHALL load the LED-counter image: mem[0]=8'hA0, mem[1]=8'h30, mem[2]=8'h60, mem[3]=8'h91, mem[4..15]=8'h00.
REQ-032 Without PROG_LOADER_BOOT_IMAGE_EN, reset SHALL clear all 16 words to 8'h00.

Verification
REQ-033 Boot: macro defined, release reset, sweep adr 0-4 -> dout A0,30,60,91,00; cpu_reset=1 from first edge after release.
REQ-034 Good load: ld_start, then 32 nibbles for words 8'h01..8'h10 plus checksum 8'h88, with ld_valid toggling randomly -> busy=1 and cpu_reset=0 throughout the load; cpu_reset=1 exactly 2 cycles after the last nibble; adr=4'hF -> dout=8'h10; err=0.
REQ-035 Bad checksum: same load with checksum 8'h87 -> err=1, state ERR, cpu_reset=0, dout=8'h00; ld_start then good load -> err=0, run.
REQ-036 Ignored inputs: ld_valid=1 in RUN -> ld_ready=0, mem unchanged; ld_start pulsed mid-load -> pointer unchanged, load continues.
REQ-037 Reset mid-load: assert reset after 10 nibbles, macro undefined -> dout=8'h00 at every adr after release, err=0, cpu_reset=1.
REQ-038 Seed: CKSUM_SEED=8'h5A, all-zero image -> checksum 8'h5A accepted, 8'h00 rejected.
